// File: rtl/bhb_sweep_ctrl_if.sv
// BHB write-port controller bus: EX-stage update request, table read/write port and status.
interface bhb_sweep_ctrl_if #(
    parameter int unsigned Size = 1024,
    parameter int unsigned CntW = 32
);
    localparam int unsigned Idx  = $clog2(Size);
    localparam int unsigned EntW = 30 - Idx + 3;

    logic            flush;
    logic            upd_valid;
    logic [29:0]     upd_pc;
    logic            upd_taken;
    logic            upd_pred_taken;
    logic [Idx-1:0]  tbl_raddr;
    logic [EntW-1:0] tbl_rdata;
    logic            tbl_we;
    logic [Idx-1:0]  tbl_waddr;
    logic [EntW-1:0] tbl_wdata;
    logic            ready;
    logic            pred_en;
    logic [CntW-1:0] upd_cnt;
    logic [CntW-1:0] miss_cnt;

    modport master (
        output flush, upd_valid, upd_pc, upd_taken, upd_pred_taken, tbl_rdata,
        input  tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, ready, pred_en, upd_cnt, miss_cnt
    );

    modport slave (
        input  flush, upd_valid, upd_pc, upd_taken, upd_pred_taken, tbl_rdata,
        output tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, ready, pred_en, upd_cnt, miss_cnt
    );
endinterface

// File: rtl/bhb_sweep_ctrl.sv
// BHB write-port owner: invalidate sweep after reset/flush, then saturating-counter
// read-modify-write of resolved branches with same-index bypass and update/miss statistics.
module bhb_sweep_ctrl #(
    parameter int unsigned Size = 1024,
    parameter int unsigned CntW = 32
) (
    input logic              clk_i,
    input logic              rstn_i,
    bhb_sweep_ctrl_if.slave  bus_io
);
    localparam int unsigned Idx  = $clog2(Size);
    localparam int unsigned Tag  = 30 - Idx;
    localparam int unsigned EntW = Tag + 3;

    typedef enum logic {StSweep, StReady} state_e;

    state_e          state_q, state_d;
    logic [Idx-1:0]  idx_q, idx_d;
    logic            tbl_we_q, tbl_we_d;
    logic [Idx-1:0]  tbl_waddr_q, tbl_waddr_d;
    logic [EntW-1:0] tbl_wdata_q, tbl_wdata_d;
    logic            ready_q, ready_d;
    logic [CntW-1:0] upd_cnt_q, upd_cnt_d;
    logic [CntW-1:0] miss_cnt_q, miss_cnt_d;

    logic [Idx-1:0]  upd_idx;
    logic [Tag-1:0]  upd_tag;
    logic [EntW-1:0] src_entry;
    logic            bypass, hit, accept, mispredict;
    logic [1:0]      ctr_old, ctr_new;

    assign upd_idx    = bus_io.upd_pc[Idx-1:0];
    assign upd_tag    = bus_io.upd_pc[29:Idx];
    // The registered write has not reached storage yet, so it shadows the table read.
    assign bypass     = tbl_we_q && (tbl_waddr_q == upd_idx);
    assign src_entry  = bypass ? tbl_wdata_q : bus_io.tbl_rdata;
    assign hit        = src_entry[EntW-1] && (src_entry[EntW-2:2] == upd_tag);
    assign ctr_old    = hit ? src_entry[1:0] : 2'b01;
    assign accept     = ready_q && bus_io.upd_valid && !bus_io.flush;
    assign mispredict = bus_io.upd_taken != bus_io.upd_pred_taken;

    always_comb begin
        ctr_new = ctr_old;
        if (bus_io.upd_taken) begin
            if (ctr_old != 2'b11) ctr_new = ctr_old + 2'd1;
        end else begin
            if (ctr_old != 2'b00) ctr_new = ctr_old - 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tbl_we_d    = 1'b0;
        tbl_waddr_d = tbl_waddr_q;
        tbl_wdata_d = tbl_wdata_q;
        ready_d     = 1'b0;
        upd_cnt_d   = upd_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        unique case (state_q)
            StSweep: begin
                tbl_we_d    = 1'b1;
                tbl_waddr_d = idx_q;
                tbl_wdata_d = EntW'(1);
                if (bus_io.flush) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + Idx'(1);
                    if (idx_q == Idx'(Size - 1)) state_d = StReady;
                end
            end
            StReady: begin
                if (bus_io.flush) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end else begin
                    ready_d = 1'b1;
                    if (accept) begin
                        tbl_we_d    = 1'b1;
                        tbl_waddr_d = upd_idx;
                        tbl_wdata_d = {1'b1, upd_tag, ctr_new};
                    end
                end
            end
        endcase

        if (accept && (upd_cnt_q != '1)) upd_cnt_d = upd_cnt_q + CntW'(1);
        if (accept && mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StSweep;
            idx_q       <= '0;
            tbl_we_q    <= 1'b0;
            tbl_waddr_q <= '0;
            tbl_wdata_q <= '0;
            ready_q     <= 1'b0;
            upd_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tbl_we_q    <= tbl_we_d;
            tbl_waddr_q <= tbl_waddr_d;
            tbl_wdata_q <= tbl_wdata_d;
            ready_q     <= ready_d;
            upd_cnt_q   <= upd_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus_io.tbl_raddr = upd_idx;
    assign bus_io.tbl_we    = tbl_we_q;
    assign bus_io.tbl_waddr = tbl_waddr_q;
    assign bus_io.tbl_wdata = tbl_wdata_q;
    assign bus_io.ready     = ready_q;
    assign bus_io.pred_en   = ready_q;
    assign bus_io.upd_cnt   = upd_cnt_q;
    assign bus_io.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_bhb_sweep_ctrl.sv
// Bench for bhb_sweep_ctrl: architectural table model feeds an expected-write queue that a
// negedge monitor drains; directed cases pin the documented corner behaviour.
module tb_bhb_sweep_ctrl;
    localparam int unsigned Size   = 16;
    localparam int unsigned CntW   = 4;
    localparam int unsigned Idx    = 4;
    localparam int unsigned Tag    = 26;
    localparam int unsigned EntW   = 29;
    localparam int          CntMax = (1 << CntW) - 1;

    typedef struct packed {
        logic [Idx-1:0]  a;
        logic [EntW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bhb_sweep_ctrl_if #(.Size(Size), .CntW(CntW)) bus ();

    bhb_sweep_ctrl #(.Size(Size), .CntW(CntW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus_io (bus)
    );

    // Storage behind the write port: lags the registered write by one edge.
    logic [EntW-1:0] mem [Size];
    always @(posedge clk) if (bus.tbl_we) mem[bus.tbl_waddr] <= bus.tbl_wdata;
    assign bus.tbl_rdata = mem[bus.tbl_raddr];

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: architectural table contents, sweep progress, statistics.
    wr_t exp_q[$];
    bit  m_sweep;
    int  m_pos;
    bit  m_ready;
    int  m_upd, m_miss;
    bit  tv [Size];
    int  ttag [Size];
    int  tctr [Size];

    always @(posedge clk or negedge rstn) begin
        bit  acc;
        int  ix, tg, c;
        wr_t w;
        if (!rstn) begin
            m_sweep = 1; m_pos = 0; m_ready = 0; m_upd = 0; m_miss = 0;
            exp_q.delete();
        end else begin
            acc = m_ready && bus.upd_valid && !bus.flush;
            if (m_sweep) begin
                w.a = Idx'(m_pos);
                w.d = EntW'(1);
                exp_q.push_back(w);
                m_ready = 0;
                if (bus.flush) m_pos = 0;
                else if (m_pos == Size - 1) begin
                    m_sweep = 0;
                    m_pos = 0;
                    for (int i = 0; i < Size; i++) tv[i] = 0;
                end else m_pos++;
            end else if (bus.flush) begin
                m_sweep = 1; m_pos = 0; m_ready = 0;
            end else begin
                m_ready = 1;
                if (acc) begin
                    ix = int'(bus.upd_pc) % Size;
                    tg = int'(bus.upd_pc) / Size;
                    c  = (tv[ix] && ttag[ix] == tg) ? tctr[ix] : 1;
                    c  = bus.upd_taken ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
                    tv[ix] = 1; ttag[ix] = tg; tctr[ix] = c;
                    w.a = Idx'(ix);
                    w.d = {1'b1, Tag'(tg), 2'(c)};
                    exp_q.push_back(w);
                    if (m_upd < CntMax) m_upd++;
                    if (bus.upd_taken != bus.upd_pred_taken && m_miss < CntMax) m_miss++;
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (rstn) begin
            if (bus.tbl_we) begin
                if (exp_q.size() == 0) chk("unexpected_write", 0, bus.tbl_waddr, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("write_addr", bus.tbl_waddr == e.a, bus.tbl_waddr, e.a);
                    chk("write_data", bus.tbl_wdata == e.d, bus.tbl_wdata, e.d);
                end
            end
            chk("missing_write", exp_q.size() == 0, exp_q.size(), 0);
            chk("ready", bus.ready == m_ready, bus.ready, m_ready);
            chk("pred_en", bus.pred_en == m_ready, bus.pred_en, m_ready);
            chk("upd_cnt", int'(bus.upd_cnt) == m_upd, bus.upd_cnt, m_upd);
            chk("miss_cnt", int'(bus.miss_cnt) == m_miss, bus.miss_cnt, m_miss);
        end
    end

    task automatic step(input bit v, input logic [29:0] pc, input bit t, input bit p, input bit f);
        @(negedge clk);
        #1;
        bus.upd_valid = v; bus.upd_pc = pc; bus.upd_taken = t;
        bus.upd_pred_taken = p; bus.flush = f;
    endtask

    task automatic idle();
        step(0, 30'h0, 0, 0, 0);
    endtask

    // Apply one update and check the counter written at the following edge.
    task automatic upd_chk(input logic [29:0] pc, input bit t, input logic [1:0] ctr);
        step(1, pc, t, t, 0);
        @(posedge clk);
        #1;
        chk("upd_ctr", bus.tbl_we && bus.tbl_wdata[1:0] == ctr, bus.tbl_wdata[1:0], ctr);
    endtask

    task automatic chk_reset();
        chk("rst_we", bus.tbl_we == 0, bus.tbl_we, 0);
        chk("rst_waddr", bus.tbl_waddr == 0, bus.tbl_waddr, 0);
        chk("rst_wdata", bus.tbl_wdata == 0, bus.tbl_wdata, 0);
        chk("rst_ready", bus.ready == 0 && bus.pred_en == 0, bus.ready, 0);
        chk("rst_cnts", bus.upd_cnt == 0 && bus.miss_cnt == 0, bus.upd_cnt, 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !m_ready; i++) idle();
        chk("ready_timeout", bus.ready == 1, bus.ready, 1);
    endtask

    initial begin
        bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0;
        bus.upd_pred_taken = 0; bus.flush = 0;
        #12;
        chk_reset();
        @(negedge clk);
        #1 rstn = 1;

        // Sweep: ready must rise at edge Size+1.
        repeat (Size) @(posedge clk);
        #1 chk("ready_edge16", bus.ready == 0, bus.ready, 0);
        @(posedge clk);
        #1 chk("ready_edge17", bus.ready == 1, bus.ready, 1);

        // First update, invalid entry: ctr 01 -> 10.
        step(1, 30'h40, 1, 1, 0);
        @(posedge clk);
        #1;
        chk("upd0_waddr", bus.tbl_we && bus.tbl_waddr == 0, bus.tbl_waddr, 0);
        chk("upd0_wdata", bus.tbl_wdata == {1'b1, 26'd4, 2'b10}, bus.tbl_wdata,
            {1'b1, 26'd4, 2'b10});
        chk("upd0_cnt", bus.upd_cnt == 1, bus.upd_cnt, 1);

        // Back-to-back same index relies on bypass; saturation both ways.
        upd_chk(30'h41, 1, 2'b10);
        upd_chk(30'h41, 1, 2'b11);
        upd_chk(30'h41, 1, 2'b11);
        upd_chk(30'h41, 0, 2'b10);
        upd_chk(30'h41, 0, 2'b01);
        upd_chk(30'h41, 0, 2'b00);
        upd_chk(30'h41, 0, 2'b00);

        // Tag mismatch restarts from 01; then a non-bypassed read from storage.
        step(1, 30'h81, 0, 0, 0);
        @(posedge clk);
        #1 chk("tagmiss_wdata", bus.tbl_wdata == {1'b1, 26'd8, 2'b00}, bus.tbl_wdata,
               {1'b1, 26'd8, 2'b00});
        idle();
        idle();
        upd_chk(30'h81, 1, 2'b01);

        // Flush with a same-cycle update: no write, counters hold, sweep starts.
        step(1, 30'h41, 1, 0, 1);
        @(posedge clk);
        #1;
        chk("flush_nowrite", bus.tbl_we == 0, bus.tbl_we, 0);
        chk("flush_cnts", bus.upd_cnt == 10 && bus.miss_cnt == 0, bus.upd_cnt, 10);
        repeat (7) idle();
        step(0, 30'h0, 0, 0, 1);
        @(posedge clk);
        #1 chk("flush_inflight", bus.tbl_waddr == 7, bus.tbl_waddr, 7);
        idle();
        @(posedge clk);
        #1 chk("flush_restart", bus.tbl_we && bus.tbl_waddr == 0, bus.tbl_waddr, 0);
        repeat (Size - 1) @(posedge clk);
        #1 chk("reflush_notready", bus.ready == 0, bus.ready, 0);
        @(posedge clk);
        #1 chk("reflush_ready", bus.ready == 1, bus.ready, 1);

        // Random stream with colliding indices/tags and occasional flushes.
        for (int i = 0; i < 120; i++) begin
            step($urandom_range(0, 3) != 0,
                 30'(($urandom_range(0, 2) << 4) | $urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0);
        end

        // Async reset mid-stream.
        @(posedge clk);
        #3 rstn = 0;
        #1 chk_reset();
        @(negedge clk);
        #1 rstn = 1;
        wait_ready();

        // Statistics saturate at all-ones.
        for (int i = 0; i < 20; i++) begin
            step(1, 30'($urandom_range(0, 63)), i[0], !i[0], 0);
        end
        @(posedge clk);
        #1 chk("sat_cnts", bus.upd_cnt == 15 && bus.miss_cnt == 15, bus.miss_cnt, 15);
        idle();
        step(1, 30'h22, 1, 1, 0);
        step(1, 30'h22, 0, 1, 0);
        @(posedge clk);
        #3 rstn = 0;
        #1 chk_reset();
        @(negedge clk);
        #1 rstn = 1;
        bus.upd_valid = 0;
        repeat (20) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
